// File: rtl/heartbeat_pkg.sv
// Shared defaults and helpers for the multi-channel heartbeat rate monitor.
package heartbeat_pkg;

  localparam int DEF_CHANNELS          = 4;
  localparam int DEF_WINDOW_CYCLES     = 2000;
  localparam int DEF_SCALE_FACTOR      = 30;
  localparam int DEF_CNT_W             = 6;
  localparam int DEF_BPM_W             = 8;
  localparam int DEF_REFRACTORY_CYCLES = 200;
  localparam int DEF_AVG_DEPTH         = 4;
  localparam int DEF_LO_BPM            = 40;
  localparam int DEF_HI_BPM            = 180;

  function automatic int clog2(input int unsigned value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++)
      if ((32'd1 << i) < value) result = i + 1;
    return result;
  endfunction

  // Full-width product clamped to max_value; callers truncate to their output width.
  function automatic longint unsigned sat_mul(input longint unsigned a,
                                              input longint unsigned b,
                                              input longint unsigned max_value);
    longint unsigned product;
    product = a * b;
    return (product > max_value) ? max_value : product;
  endfunction

endpackage

// File: rtl/heartbeat_channel.sv
// One beat channel: synchroniser, edge detect, refractory lockout, beat counter, rate and alarms.
// HEARTBEAT_AVG_EN adds an AVG_DEPTH-window moving average ahead of the output register.
module heartbeat_channel
  import heartbeat_pkg::*;
#(
  parameter int CNT_W             = DEF_CNT_W,
  parameter int BPM_W             = DEF_BPM_W,
  parameter int SCALE_FACTOR      = DEF_SCALE_FACTOR,
  parameter int REFRACTORY_CYCLES = DEF_REFRACTORY_CYCLES,
  parameter int AVG_DEPTH         = DEF_AVG_DEPTH,
  parameter int LO_BPM            = DEF_LO_BPM,
  parameter int HI_BPM            = DEF_HI_BPM
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pulse_in,
  input  logic             terminal,
  output logic [BPM_W-1:0] bpm,
  output logic             alarm_lo,
  output logic             alarm_hi
);

  localparam int LOCK_W = (REFRACTORY_CYCLES > 0) ? clog2(REFRACTORY_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam longint unsigned BPM_MAX = (64'd1 << BPM_W) - 64'd1;

  if (AVG_DEPTH < 2 || (AVG_DEPTH & (AVG_DEPTH - 1)) != 0) begin : g_bad_avg_depth
    $error("heartbeat_channel: AVG_DEPTH must be a power of two >= 2");
  end

  logic [2:0]        sync_q;
  logic              rise;
  logic              accept;
  logic              upd;
  logic [LOCK_W-1:0] lock_q;
  logic [CNT_W-1:0]  count_q;
  logic [BPM_W-1:0]  raw;
  logic [BPM_W-1:0]  bpm_next;

  // sync_q[1:0] is the two-flop synchroniser; sync_q[2] holds the previous synchronised level.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], pulse_in};
  end

  assign rise   = sync_q[1] & ~sync_q[2];
  assign accept = rise && (lock_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            lock_q <= '0;
    else if (accept)         lock_q <= LOCK_W'(REFRACTORY_CYCLES);
    else if (lock_q != '0)   lock_q <= lock_q - 1'b1;
  end

  // An edge accepted on the terminal cycle belongs to the window that starts next.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           count_q <= '0;
    else if (terminal)                      count_q <= accept ? CNT_W'(1) : '0;
    else if (accept && count_q != CNT_MAX)  count_q <= count_q + 1'b1;
  end

  assign raw = BPM_W'(sat_mul(64'(count_q), 64'(SCALE_FACTOR), BPM_MAX));

`ifdef HEARTBEAT_AVG_EN
  localparam int PTR_W = clog2(AVG_DEPTH);
  localparam int SUM_W = BPM_W + PTR_W;

  logic [BPM_W-1:0] ring_q [AVG_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_next;
  logic [BPM_W-1:0] raw_q;
  logic             pending_q;

  assign sum_next = sum_q + SUM_W'(raw_q) - SUM_W'(ring_q[ptr_q]);
  assign bpm_next = BPM_W'(sum_next >> PTR_W);
  assign upd      = pending_q;

  // NOTE: the ring is flop-based and cleared on reset because the warm-up ramp depends on zero history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < AVG_DEPTH; i++) ring_q[i] <= '0;
      ptr_q     <= '0;
      sum_q     <= '0;
      raw_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= terminal;
      if (terminal) raw_q <= raw;
      if (pending_q) begin
        ring_q[ptr_q] <= raw_q;
        ptr_q         <= ptr_q + 1'b1;
        sum_q         <= sum_next;
      end
    end
  end
`else
  assign bpm_next = raw;
  assign upd      = terminal;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bpm      <= '0;
      alarm_lo <= 1'b0;
      alarm_hi <= 1'b0;
    end else if (upd) begin
      bpm      <= bpm_next;
      alarm_lo <= (32'(bpm_next) < LO_BPM);
      alarm_hi <= (32'(bpm_next) > HI_BPM);
    end
  end

endmodule

// File: rtl/heartbeat_monitor.sv
// Multi-channel heartbeat monitor top: shared window timer, update strobe, warm flag, output packing.
// Build option HEARTBEAT_AVG_EN enables per-channel moving-average smoothing and the warm-up flag.
module heartbeat_monitor
  import heartbeat_pkg::*;
#(
  parameter int CHANNELS          = DEF_CHANNELS,
  parameter int WINDOW_CYCLES     = DEF_WINDOW_CYCLES,
  parameter int SCALE_FACTOR      = DEF_SCALE_FACTOR,
  parameter int CNT_W             = DEF_CNT_W,
  parameter int BPM_W             = DEF_BPM_W,
  parameter int REFRACTORY_CYCLES = DEF_REFRACTORY_CYCLES,
  parameter int AVG_DEPTH         = DEF_AVG_DEPTH,
  parameter int LO_BPM            = DEF_LO_BPM,
  parameter int HI_BPM            = DEF_HI_BPM
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       pulse_in,
  output logic [CHANNELS*BPM_W-1:0] bpm,
  output logic                      new_bpm,
  output logic [CHANNELS-1:0]       alarm_lo,
  output logic [CHANNELS-1:0]       alarm_hi,
  output logic                      warm
);

  localparam int TMR_W = clog2(WINDOW_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WINDOW_CYCLES - 1);

  logic [TMR_W-1:0] timer_q;
  logic             terminal;

  assign terminal = (timer_q == TMR_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      timer_q <= '0;
    else if (terminal) timer_q <= '0;
    else               timer_q <= timer_q + 1'b1;
  end

`ifdef HEARTBEAT_AVG_EN
  localparam int WARM_W = clog2(AVG_DEPTH);

  logic              terminal_d_q;
  logic [WARM_W-1:0] strobe_cnt_q;
  logic              warm_q;

  // The averaging stage adds a cycle, so the strobe follows the delayed terminal.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      terminal_d_q <= 1'b0;
      new_bpm      <= 1'b0;
      strobe_cnt_q <= '0;
      warm_q       <= 1'b0;
    end else begin
      terminal_d_q <= terminal;
      new_bpm      <= terminal_d_q;
      if (terminal_d_q && !warm_q) begin
        if (strobe_cnt_q == WARM_W'(AVG_DEPTH - 1)) warm_q <= 1'b1;
        else                                        strobe_cnt_q <= strobe_cnt_q + 1'b1;
      end
    end
  end

  assign warm = warm_q;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) new_bpm <= 1'b0;
    else          new_bpm <= terminal;
  end

  assign warm = 1'b1;
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    heartbeat_channel #(
      .CNT_W             (CNT_W),
      .BPM_W             (BPM_W),
      .SCALE_FACTOR      (SCALE_FACTOR),
      .REFRACTORY_CYCLES (REFRACTORY_CYCLES),
      .AVG_DEPTH         (AVG_DEPTH),
      .LO_BPM            (LO_BPM),
      .HI_BPM            (HI_BPM)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .pulse_in (pulse_in[c]),
      .terminal (terminal),
      .bpm      (bpm[c*BPM_W +: BPM_W]),
      .alarm_lo (alarm_lo[c]),
      .alarm_hi (alarm_hi[c])
    );
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Self-checking bench for heartbeat_monitor: beat schedules are replayed on the pins and every
// strobe is compared with rates derived from a schedule-level model (also valid with HEARTBEAT_AVG_EN).
module tb_heartbeat_monitor;

  localparam int CH    = 4;
  localparam int WIN   = 2000;
  localparam int SCALE = 30;
  localparam int CNT_W = 6;
  localparam int BPM_W = 8;
  localparam int REF   = 200;
  localparam int AVG   = 4;
  localparam int LO    = 40;
  localparam int HI    = 180;
  localparam int NWIN  = 8;
  localparam int PIN_TO_ACCEPT = 3;
  localparam int DATA_W = CH*BPM_W + 2*CH + 1;
`ifdef HEARTBEAT_AVG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct { int t; int w; } beat_t;
  typedef struct { int cyc; logic [DATA_W-1:0] data; } obs_t;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [CH-1:0]          pulse_in;
  logic [CH*BPM_W-1:0]    bpm;
  logic                   new_bpm;
  logic [CH-1:0]          alarm_lo;
  logic [CH-1:0]          alarm_hi;
  logic                   warm;

  beat_t beats [CH][$];
  obs_t  obs [$];
  int    exp_cnt [CH][NWIN];
  int    cyc;
  int    checks = 0;
  int    errors = 0;

  heartbeat_monitor #(
    .CHANNELS (CH), .WINDOW_CYCLES (WIN), .SCALE_FACTOR (SCALE), .CNT_W (CNT_W),
    .BPM_W (BPM_W), .REFRACTORY_CYCLES (REF), .AVG_DEPTH (AVG), .LO_BPM (LO), .HI_BPM (HI)
  ) dut (
    .clk (clk), .reset_n (reset_n), .pulse_in (pulse_in), .bpm (bpm), .new_bpm (new_bpm),
    .alarm_lo (alarm_lo), .alarm_hi (alarm_hi), .warm (warm)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: an edge is accepted if it comes more than REF cycles after the last accepted one;
  // accepted edges are binned by window and the count saturates at the counter's maximum.
  task automatic build_model();
    int last, n, w;
    for (int c = 0; c < CH; c++) begin
      for (int k = 0; k < NWIN; k++) exp_cnt[c][k] = 0;
      last = -1000000;
      foreach (beats[c][i]) begin
        n = beats[c][i].t + PIN_TO_ACCEPT;
        if (n - last > REF) begin
          last = n;
          w = n / WIN;
          if (w < NWIN && exp_cnt[c][w] < (1 << CNT_W) - 1) exp_cnt[c][w]++;
        end
      end
    end
  endtask

  function automatic int raw_of(int c, int w);
    int p;
    if (w < 0) return 0;
    p = exp_cnt[c][w] * SCALE;
    return (p > (1 << BPM_W) - 1) ? (1 << BPM_W) - 1 : p;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(int w);
    logic [CH*BPM_W-1:0] b;
    logic [CH-1:0]       lo, hi;
    logic                wm;
    int                  v;
    for (int c = 0; c < CH; c++) begin
`ifdef HEARTBEAT_AVG_EN
      v = 0;
      for (int k = 0; k < AVG; k++) v += raw_of(c, w - k);
      v = v / AVG;
      wm = (w + 1 >= AVG);
`else
      v = raw_of(c, w);
      wm = 1'b1;
`endif
      b[c*BPM_W +: BPM_W] = v[BPM_W-1:0];
      lo[c] = (v < LO);
      hi[c] = (v > HI);
    end
    return {b, lo, hi, wm};
  endfunction

  task automatic do_reset();
    reset_n  = 1'b0;
    pulse_in = '0;
    for (int c = 0; c < CH; c++) beats[c].delete();
    obs.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // Replays the beat schedule on the pins and records every cycle where new_bpm is high.
  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      #1;
      for (int c = 0; c < CH; c++) begin
        pulse_in[c] = 1'b0;
        foreach (beats[c][i])
          if (cyc >= beats[c][i].t && cyc < beats[c][i].t + beats[c][i].w) pulse_in[c] = 1'b1;
      end
      if (new_bpm === 1'b1) obs.push_back('{cyc, {bpm, alarm_lo, alarm_hi, warm}});
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pulse_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bpm, new_bpm, alarm_lo, alarm_hi} !== '0) begin
      errors++;
      $display("FAIL reset_held outputs: got %h expected 0", {bpm, new_bpm, alarm_lo, alarm_hi});
    end
    do_reset();
    #1;
    checks++;
    if (bpm !== '0) begin errors++; $display("FAIL reset bpm: got %h expected 0", bpm); end
    checks++;
    if (new_bpm !== 1'b0) begin errors++; $display("FAIL reset new_bpm: got %b expected 0", new_bpm); end
    checks++;
    if ({alarm_lo, alarm_hi} !== '0) begin
      errors++;
      $display("FAIL reset alarms: got %b expected 0", {alarm_lo, alarm_hi});
    end
    checks++;
    if (warm !== (LAT == 1)) begin errors++; $display("FAIL reset warm: got %b expected %b", warm, LAT == 1); end
  endtask

  task automatic test_single_60();
    do_reset();
    for (int k = 0; k < 6; k++) beats[0].push_back('{100 + 1000*k, 5});
    build_model();
    run_cycles(WIN*3 + LAT + 3);
    checks++;
    if (obs.size() != 3) begin errors++; $display("FAIL single60 strobes: got %0d expected 3", obs.size()); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].cyc != WIN*(i+1) + LAT - 1) begin
        errors++; $display("FAIL single60 strobe_cycle %0d: got %0d expected %0d", i, obs[i].cyc, WIN*(i+1) + LAT - 1);
      end
      checks++;
      if (obs[i].data !== exp_data(i)) begin
        errors++; $display("FAIL single60 data %0d: got %h expected %h", i, obs[i].data, exp_data(i));
      end
    end
  endtask

  task automatic test_multi_rate();
    do_reset();
    for (int t = 30; t < WIN*3; t += 667) beats[1].push_back('{t, 4});
    for (int t = 60; t < WIN*3; t += 500) beats[2].push_back('{t, 6});
    for (int t = 20; t < WIN*3; t += 285) beats[3].push_back('{t, 3});
    build_model();
    run_cycles(WIN*3 + LAT + 3);
    checks++;
    if (obs.size() != 3) begin errors++; $display("FAIL multi strobes: got %0d expected 3", obs.size()); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].cyc != WIN*(i+1) + LAT - 1) begin
        errors++; $display("FAIL multi strobe_cycle %0d: got %0d expected %0d", i, obs[i].cyc, WIN*(i+1) + LAT - 1);
      end
      checks++;
      if (obs[i].data !== exp_data(i)) begin
        errors++; $display("FAIL multi data %0d: got %h expected %h", i, obs[i].data, exp_data(i));
      end
    end
  endtask

  // Window 0: pair 50 apart (second dropped). Window 1: pair 300 apart.
  // Window 3: an edge accepted exactly on the terminal cycle of window 2.
  task automatic test_refractory();
    do_reset();
    beats[0].push_back('{100, 5});
    beats[0].push_back('{150, 5});
    beats[0].push_back('{2100, 5});
    beats[0].push_back('{2400, 5});
    beats[0].push_back('{3*WIN - PIN_TO_ACCEPT, 5});
    build_model();
    run_cycles(WIN*4 + LAT + 3);
    checks++;
    if (obs.size() != 4) begin errors++; $display("FAIL refractory strobes: got %0d expected 4", obs.size()); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].data !== exp_data(i)) begin
        errors++; $display("FAIL refractory data %0d: got %h expected %h", i, obs[i].data, exp_data(i));
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 10; k++) beats[0].push_back('{10 + 205*k, 5});
    build_model();
    run_cycles(WIN + LAT + 3);
    checks++;
    if (obs.size() != 1) begin errors++; $display("FAIL saturation strobes: got %0d expected 1", obs.size()); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].data !== exp_data(i)) begin
        errors++; $display("FAIL saturation data %0d: got %h expected %h", i, obs[i].data, exp_data(i));
      end
    end
  endtask

  task automatic test_random();
    int t;
    do_reset();
    for (int c = 0; c < CH; c++) begin
      t = $urandom_range(300, 1);
      while (t < WIN*4 - 50) begin
        beats[c].push_back('{t, int'($urandom_range(8, 1))});
        t += $urandom_range(600, 20);
      end
    end
    build_model();
    run_cycles(WIN*4 + LAT + 3);
    checks++;
    if (obs.size() != 4) begin errors++; $display("FAIL random strobes: got %0d expected 4", obs.size()); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].cyc != WIN*(i+1) + LAT - 1) begin
        errors++; $display("FAIL random strobe_cycle %0d: got %0d expected %0d", i, obs[i].cyc, WIN*(i+1) + LAT - 1);
      end
      checks++;
      if (obs[i].data !== exp_data(i)) begin
        errors++; $display("FAIL random data %0d: got %h expected %h", i, obs[i].data, exp_data(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    do_reset();
    beats[0].push_back('{300, 5});
    beats[0].push_back('{900, 5});
    run_cycles(1500);
    reset_n  = 1'b0;
    pulse_in = '0;
    #1;
    checks++;
    if ({bpm, new_bpm, alarm_lo, alarm_hi} !== '0) begin
      errors++; $display("FAIL reset_mid outputs: got %h expected 0", {bpm, new_bpm, alarm_lo, alarm_hi});
    end
    stray = 0;
    for (int k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      if (new_bpm !== 1'b0) stray++;
    end
    checks++;
    if (stray + obs.size() != 0) begin
      errors++; $display("FAIL reset_mid no_strobe: got %0d strobes expected 0", stray + obs.size());
    end
    for (int c = 0; c < CH; c++) beats[c].delete();
    obs.delete();
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    build_model();
    run_cycles(WIN + LAT + 3);
    checks++;
    if (obs.size() != 1) begin errors++; $display("FAIL reset_mid strobes: got %0d expected 1", obs.size()); end
    foreach (obs[i]) begin
      checks++;
      if (obs[i].cyc != WIN + LAT - 1) begin
        errors++; $display("FAIL reset_mid strobe_cycle: got %0d expected %0d", obs[i].cyc, WIN + LAT - 1);
      end
      checks++;
      if (obs[i].data !== exp_data(0)) begin
        errors++; $display("FAIL reset_mid data: got %h expected %h", obs[i].data, exp_data(0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_60();
    test_multi_rate();
    test_refractory();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
